// File: rtl/batrider_cen_pkg.sv
// Shared types and constants for the batrider fractional
// clock-enable controller.
package batrider_cen_pkg;

  localparam int CEN_NCH = 4;
  localparam int CEN_WC  = 17;
  localparam int CEN_CHW = $clog2(CEN_NCH);

  typedef logic [CEN_CHW-1:0] cen_ch_t;
  typedef logic [CEN_WC-1:0]  cen_val_t;

  typedef struct packed {
    cen_val_t n;
    cen_val_t m;
  } cen_cfg_t;

  // A ratio can only run when 0 < n <= m.
  function automatic logic cfg_valid(cen_cfg_t c);
    return (c.n != '0) && (c.m != '0) && (c.n <= c.m);
  endfunction

endpackage

// File: rtl/batrider_cen_ctrl_if.sv
// Config, control and enable-pulse bundle between the
// system side (master) and the CEN controller (slave).
interface batrider_cen_ctrl_if;
  import batrider_cen_pkg::*;

  logic                 CFG_WE;
  cen_ch_t              CFG_CH;
  cen_val_t             CFG_N;
  cen_val_t             CFG_M;
  logic [CEN_NCH-1:0]   CFG_BUSY;
  logic                 CFG_ERR;
  logic                 PAUSE;
  logic                 SYNC;
  logic [CEN_NCH-1:0]   CEN;
  logic [CEN_NCH-1:0]   CENB;

  modport master (
    output CFG_WE, CFG_CH, CFG_N, CFG_M,
    output PAUSE, SYNC,
    input  CFG_BUSY, CFG_ERR, CEN, CENB
  );

  modport slave (
    input  CFG_WE, CFG_CH, CFG_N, CFG_M,
    input  PAUSE, SYNC,
    output CFG_BUSY, CFG_ERR, CEN, CENB
  );

endinterface

// File: rtl/batrider_cen_chan.sv
// One fractional n/m enable channel: accumulator, half-phase
// flag, pending config slot and busy flag.
module batrider_cen_chan
  import batrider_cen_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr_i,
  input  cen_cfg_t cfg_i,
  input  logic     pause_i,
  input  logic     sync_i,
  output logic     busy_o,
  output logic     cen_o,
  output logic     cenb_o
);

  cen_cfg_t cur_q, cur_d;
  cen_cfg_t pend_q, pend_d;
  cen_val_t cnt_q, cnt_d;
  logic     half_q, half_d;
  logic     busy_q, busy_d;
  logic     cen_q, cen_d;
  logic     cenb_q, cenb_d;

  logic [CEN_WC:0] sum;
  logic [CEN_WC:0] m_ext;
  logic [CEN_WC:0] m_half;
  logic            valid;

  assign sum    = {1'b0, cnt_q} + {1'b0, cur_q.n};
  assign m_ext  = {1'b0, cur_q.m};
  assign m_half = {2'b00, cur_q.m[CEN_WC-1:1]};
  assign valid  = cfg_valid(cur_q);

  // Accumulate, decide pulses, apply pending config, latch writes.
  always_comb begin
    cur_d  = cur_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    half_d = half_q;
    busy_d = busy_q;
    cen_d  = 1'b0;
    cenb_d = 1'b0;
    if (sync_i) begin
      cnt_d  = '0;
      half_d = 1'b0;
      if (busy_q) begin
        cur_d  = pend_q;
        busy_d = 1'b0;
      end
    end else if (!pause_i) begin
      if (!valid) begin
        cnt_d  = '0;
        half_d = 1'b0;
        if (busy_q) begin
          cur_d  = pend_q;
          busy_d = 1'b0;
        end
      end else if (sum >= m_ext) begin
        cen_d  = 1'b1;
        cnt_d  = cnt_q + cur_q.n - cur_q.m;
        half_d = 1'b0;
        if (busy_q) begin
          cur_d  = pend_q;
          cnt_d  = '0;
          busy_d = 1'b0;
        end
      end else if (!half_q && sum >= m_half) begin
        cenb_d = 1'b1;
        cnt_d  = sum[CEN_WC-1:0];
        half_d = 1'b1;
      end else begin
        cnt_d  = sum[CEN_WC-1:0];
      end
    end
    // SYNC has just applied the old pending, so a
    // coincident write is always taken as the new one.
    if (wr_i && (!busy_q || sync_i)) begin
      pend_d = cfg_i;
      busy_d = 1'b1;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      half_q <= 1'b0;
      busy_q <= 1'b0;
      cen_q  <= 1'b0;
      cenb_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      half_q <= half_d;
      busy_q <= busy_d;
      cen_q  <= cen_d;
      cenb_q <= cenb_d;
    end
  end

  assign busy_o = busy_q;
  assign cen_o  = cen_q;
  assign cenb_o = cenb_q;

endmodule

// File: rtl/batrider_cen_ctrl.sv
// Runtime-programmable bank of fractional CEN/CENB generators
// with write decode, reject pulse and PAUSE/SYNC fan-out.
module batrider_cen_ctrl
  import batrider_cen_pkg::*;
#(
  parameter int NCH = CEN_NCH,
  parameter int WC  = CEN_WC
) (
  input logic               CLK96,
  input logic               RESETn,
  batrider_cen_ctrl_if.slave bus
);

  logic [NCH-1:0] wr_w;
  logic [NCH-1:0] busy_w;
  logic [NCH-1:0] cen_w;
  logic [NCH-1:0] cenb_w;
  logic [WC-1:0]  wn_w;
  logic [WC-1:0]  wm_w;
  cen_cfg_t       cfg_w;
  logic           err_q, err_d;

  assign wn_w  = bus.CFG_N;
  assign wm_w  = bus.CFG_M;
  assign cfg_w = '{n: wn_w, m: wm_w};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_w[i] = bus.CFG_WE &&
                     (bus.CFG_CH == cen_ch_t'(i));

    batrider_cen_chan u_chan (
      .clk     (CLK96),
      .rst_n   (RESETn),
      .wr_i    (wr_w[i]),
      .cfg_i   (cfg_w),
      .pause_i (bus.PAUSE),
      .sync_i  (bus.SYNC),
      .busy_o  (busy_w[i]),
      .cen_o   (cen_w[i]),
      .cenb_o  (cenb_w[i])
    );
  end

  // A write to a busy channel is rejected unless SYNC
  // frees the slot in the same cycle.
  always_comb begin
    err_d = bus.CFG_WE && busy_w[bus.CFG_CH] && !bus.SYNC;
  end

  // Registered one-cycle reject pulse.
  always_ff @(posedge CLK96 or negedge RESETn) begin
    if (!RESETn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.CFG_BUSY = busy_w;
  assign bus.CFG_ERR  = err_q;
  assign bus.CEN      = cen_w;
  assign bus.CENB     = cenb_w;

endmodule

// File: tb/tb_batrider_cen_ctrl.sv
// Directed self-checking bench for batrider_cen_ctrl.
module tb_batrider_cen_ctrl;
  import batrider_cen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  batrider_cen_ctrl_if bus ();

  batrider_cen_ctrl dut (
    .CLK96  (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input int ch, input int n,
                           input int m);
    bus.CFG_WE = 1'b1;
    bus.CFG_CH = cen_ch_t'(ch);
    bus.CFG_N  = cen_val_t'(n);
    bus.CFG_M  = cen_val_t'(m);
    step();
    bus.CFG_WE = 1'b0;
  endtask

  task automatic wait_cen(input int ch, input int bound,
                          output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (bus.CEN[ch]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] mc, mb;
    logic        ok, pb;
    int          nc, nb, last, gmin, gmax, c0, pulses;

    bus.CFG_WE = 1'b0;
    bus.CFG_CH = '0;
    bus.CFG_N  = '0;
    bus.CFG_M  = '0;
    bus.PAUSE  = 1'b0;
    bus.SYNC   = 1'b0;

    // reset
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    chk("rst_cen", 32'(bus.CEN), 0);
    chk("rst_cenb", 32'(bus.CENB), 0);
    chk("rst_busy", 32'(bus.CFG_BUSY), 0);
    chk("rst_err", 32'(bus.CFG_ERR), 0);

    // 1: ch0 n=1 m=7
    cfg_write(0, 1, 7);
    chk("t1_busy_hi", 32'(bus.CFG_BUSY[0]), 1);
    step();
    chk("t1_busy_lo", 32'(bus.CFG_BUSY[0]), 0);
    mc = '0;
    mb = '0;
    for (int k = 2; k <= 22; k++) begin
      step();
      mc[k] = bus.CEN[0];
      mb[k] = bus.CENB[0];
    end
    chk("t1_cen_mask", mc, 32'h0040_8100);
    chk("t1_cenb_mask", mb, 32'h0004_0810);

    // 2: ch1 n=8 m=189 over 1890 cycles
    cfg_write(1, 8, 189);
    step();
    nc = 0;
    nb = 0;
    last = -1;
    gmin = 1000;
    gmax = 0;
    for (int i = 1; i <= 1890; i++) begin
      step();
      if (bus.CEN[1]) begin
        nc++;
        if (last >= 0) begin
          if (i - last < gmin) gmin = i - last;
          if (i - last > gmax) gmax = i - last;
        end
        last = i;
      end
      if (bus.CENB[1]) nb++;
    end
    chk("t2_cen_cnt", 32'(nc), 80);
    chk("t2_cenb_cnt", 32'(nb), 80);
    chk("t2_gap_max", 32'(gmax), 24);
    chk("t2_gap_min", 32'(gmin), 23);

    // 3: ch2 retune 1/8 -> 1/4 mid-period
    cfg_write(2, 1, 8);
    step();
    wait_cen(2, 20, ok);
    chk("t3_first_cen", 32'(ok), 1);
    step();
    step();
    step();
    cfg_write(2, 1, 4);
    chk("t3_busy", 32'(bus.CFG_BUSY[2]), 1);
    cfg_write(2, 1, 2);
    chk("t3_err_hi", 32'(bus.CFG_ERR), 1);
    step();
    chk("t3_err_lo", 32'(bus.CFG_ERR), 0);
    pb = bus.CFG_BUSY[2];
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.CEN[2]) begin
        ok = 1'b1;
        break;
      end
      pb = bus.CFG_BUSY[2];
    end
    chk("t3_apply_cen", 32'(ok), 1);
    chk("t3_busy_pre", 32'(pb), 1);
    chk("t3_busy_post", 32'(bus.CFG_BUSY[2]), 0);
    mc = '0;
    mb = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      mc[k] = bus.CEN[2];
      mb[k] = bus.CENB[2];
    end
    chk("t3_cen_mask", mc, 32'h88);
    chk("t3_cenb_mask", mb, 32'h22);

    // 4: PAUSE 50 cycles, 2 cycles after a ch0 CEN
    wait_cen(0, 10, ok);
    chk("t4_pre_cen", 32'(ok), 1);
    c0 = cyc;
    step();
    step();
    bus.PAUSE = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      pulses += $countones(bus.CEN) + $countones(bus.CENB);
    end
    bus.PAUSE = 1'b0;
    chk("t4_quiet", 32'(pulses), 0);
    wait_cen(0, 20, ok);
    chk("t4_post_cen", 32'(ok), 1);
    chk("t4_delta", 32'(cyc - c0), 32'(7 + 50));

    // 5: invalid configs, then n=m
    cfg_write(3, 0, 5);
    step();
    chk("t5_busy_a", 32'(bus.CFG_BUSY[3]), 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(bus.CEN[3]) + int'(bus.CENB[3]);
    end
    chk("t5_n0_quiet", 32'(pulses), 0);
    cfg_write(3, 9, 5);
    step();
    chk("t5_busy_b", 32'(bus.CFG_BUSY[3]), 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(bus.CEN[3]) + int'(bus.CENB[3]);
    end
    chk("t5_ngtm_quiet", 32'(pulses), 0);
    cfg_write(3, 3, 3);
    step();
    nc = 0;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      nc += int'(bus.CEN[3]);
      nb += int'(bus.CENB[3]);
    end
    chk("t5_eq_cen", 32'(nc), 10);
    chk("t5_eq_cenb", 32'(nb), 0);

    // 6: SYNC with pending on ch3, then async reset
    cfg_write(3, 1, 9);
    step();
    chk("t6_busy_a", 32'(bus.CFG_BUSY[3]), 0);
    cfg_write(3, 1, 3);
    chk("t6_busy_b", 32'(bus.CFG_BUSY[3]), 1);
    bus.SYNC = 1'b1;
    step();
    bus.SYNC = 1'b0;
    chk("t6_sync_cen", 32'(bus.CEN), 0);
    chk("t6_sync_cenb", 32'(bus.CENB), 0);
    chk("t6_sync_busy", 32'(bus.CFG_BUSY), 0);
    mc = '0;
    mb = '0;
    for (int k = 0; k < 7; k++) begin
      step();
      mc[k] = bus.CEN[3];
      mb[k] = bus.CENB[3];
      mc[8+k] = bus.CEN[0];
      mb[8+k] = bus.CENB[0];
    end
    chk("t6_ch3_cen", {24'h0, mc[7:0]}, 32'h24);
    chk("t6_ch3_cenb", {24'h0, mb[7:0]}, 32'h49);
    chk("t6_ch0_cen", {24'h0, mc[15:8]}, 32'h40);
    chk("t6_ch0_cenb", {24'h0, mb[15:8]}, 32'h04);
    cfg_write(1, 1, 2);
    chk("t6_busy_ch1", 32'(bus.CFG_BUSY[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cen", 32'(bus.CEN), 0);
    chk("t6_rst_cenb", 32'(bus.CENB), 0);
    chk("t6_rst_busy", 32'(bus.CFG_BUSY), 0);
    step();
    step();
    #3 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      pulses += $countones(bus.CEN) + $countones(bus.CENB) +
                $countones(bus.CFG_BUSY);
    end
    chk("t6_disabled", 32'(pulses), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
